// File: rtl/mem_pkg.sv
// ----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the data-memory side of the pipeline:
//   - fun3 encodings for loads and stores (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//   - default byte-address and data widths (AW_DEF, DW_DEF)
//   - store-entry record {fun3, addr, data} at the default widths
//   - access_size(): fun3 -> number of bytes touched
//   - is_store_fun3(): true for the three store encodings
// ----------------------------------------------------------------------------
package mem_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 32;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } fun3_e;

    typedef struct packed {
        logic [2:0]        fun3;
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] data;
    } st_entry_t;

    // Bytes touched by an access. Unknown encodings are treated as a full
    // word so that an odd load can only ever over-report a conflict.
    function automatic logic [2:0] access_size(input logic [2:0] fun3);
        logic [2:0] size;
        case (fun3)
            F3_B, F3_BU: size = 3'd1;
            F3_H, F3_HU: size = 3'd2;
            default:     size = 3'd4;
        endcase
        return size;
    endfunction

    function automatic logic is_store_fun3(input logic [2:0] fun3);
        return (fun3 == F3_B) || (fun3 == F3_H) || (fun3 == F3_W);
    endfunction

endpackage

// File: rtl/range_overlap.sv
// ----------------------------------------------------------------------------
// range_overlap
// Combinational test for whether two byte ranges intersect. Each range is
// [addr, addr+size-1] taken modulo 2^AW, so a range may wrap past the top of
// the address space.
// Ports:
//   a_addr_i / a_size_i : first range start and byte count (1..4)
//   b_addr_i / b_size_i : second range start and byte count (1..4)
//   overlap_o           : 1 when the ranges share at least one byte
// ----------------------------------------------------------------------------
module range_overlap #(
    parameter int AW = 8
) (
    input  logic [AW-1:0] a_addr_i,
    input  logic [2:0]    a_size_i,
    input  logic [AW-1:0] b_addr_i,
    input  logic [2:0]    b_size_i,
    output logic          overlap_o
);

    // Two ranges intersect exactly when one start lies inside the other
    // range. Measuring the modular distance between the starts handles the
    // wrap case with no special-casing.
    logic [AW-1:0] b_from_a;
    logic [AW-1:0] a_from_b;

    assign b_from_a  = b_addr_i - a_addr_i;
    assign a_from_b  = a_addr_i - b_addr_i;
    assign overlap_o = (b_from_a < AW'(a_size_i)) || (a_from_b < AW'(b_size_i));

endmodule

// File: rtl/store_buffer.sv
// ----------------------------------------------------------------------------
// store_buffer
// Posted-write buffer between the MEM-stage pipeline register and the data
// memory. Stores queue in a circular FIFO and retire on cycles when no load
// uses the memory port. A load that overlaps any queued store is stalled
// until those stores have drained, so no byte forwarding is needed.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   st_valid/st_fun3/st_addr/
//   st_data, st_ready              store handshake from the pipeline
//   ld_valid/ld_fun3/ld_addr,
//   ld_stall                       load request and stall back to pipeline
//   empty                          no stores queued
//   mem_read/mem_write/mem_fun3/
//   mem_addr/mem_wdata             data-memory port
// ----------------------------------------------------------------------------
module store_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st_valid,
    input  logic [2:0]    st_fun3,
    input  logic [AW-1:0] st_addr,
    input  logic [DW-1:0] st_data,
    output logic          st_ready,
    input  logic          ld_valid,
    input  logic [2:0]    ld_fun3,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_stall,
    output logic          empty,
    output logic          mem_read,
    output logic          mem_write,
    output logic [2:0]    mem_fun3,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [2:0]    fun3;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        entry_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic             enq;
    logic             drain;
    logic             do_read;
    logic             conflict;
    logic [DEPTH-1:0] hit;
    logic [DEPTH-1:0] live;
    logic [2:0]       ld_size;
    entry_t           head_e;

    assign ld_size = access_size(ld_fun3);
    assign head_e  = entry_q[head_q];

    // Per-entry overlap check; an entry only counts while it is queued.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PW-1:0] offset;
            logic [2:0]    ent_size;

            // Slot age relative to head decides whether the slot holds a
            // live store.
            assign offset   = PW'(gi) - head_q;
            assign live[gi] = ({1'b0, offset} < count_q);
            assign ent_size = access_size(entry_q[gi].fun3);

            range_overlap #(
                .AW(AW)
            ) u_overlap (
                .a_addr_i (entry_q[gi].addr),
                .a_size_i (ent_size),
                .b_addr_i (ld_addr),
                .b_size_i (ld_size),
                .overlap_o(hit[gi])
            );
        end
    endgenerate

    assign conflict = ld_valid && (|(hit & live));

    assign st_ready = (count_q != CW'(DEPTH));
    assign empty    = (count_q == '0);

    // Illegal store encodings still complete the handshake but are dropped.
    assign enq = st_valid && st_ready && is_store_fun3(st_fun3);

    // Loads win the port; a drain happens whenever the port is otherwise
    // free. Reset forces the idle port so nothing leaks out while it is held.
    assign do_read = !rst && ld_valid && !conflict;
    assign drain   = !rst && !do_read && !empty;
    assign ld_stall = !rst && conflict;

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_fun3  = 3'b000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (do_read) begin
            mem_read = 1'b1;
            mem_fun3 = ld_fun3;
            mem_addr = ld_addr;
        end else if (drain) begin
            mem_write = 1'b1;
            mem_fun3  = head_e.fun3;
            mem_addr  = head_e.addr;
            mem_wdata = head_e.data;
        end
    end

    always_comb begin
        head_d  = head_q + PW'(drain);
        tail_d  = tail_q + PW'(enq);
        count_d = count_q + CW'(enq) - CW'(drain);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload needs no reset: slots outside [head, head+count) are
    // ignored by both the conflict check and the drain.
    always_ff @(posedge clk) begin
        if (enq) begin
            entry_q[tail_q] <= '{fun3: st_fun3, addr: st_addr, data: st_data};
        end
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the MEM-stage pipeline register and the byte-addressable data memory.
- Stores are queued in a small FIFO and retire to memory in idle memory cycles; loads get priority on the memory port.
- A load whose byte range overlaps any queued store is stalled until the overlapping stores have drained. This keeps load results correct without byte-level forwarding.

Parameters:
- DEPTH, 4, number of store entries; power of 2, minimum 2.
- AW, 8, byte-address width, matching the data memory.
- DW, 32, data width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- st_valid  in  1  pipeline presents a store this cycle.
- st_fun3  in  3  store type: 000 SB, 001 SH, 010 SW.
- st_addr  in  AW  store byte address.
- st_data  in  DW  store data; only the low bytes per st_fun3 are meaningful.
- st_ready  out  1  buffer can accept a store this cycle.
- ld_valid  in  1  pipeline presents a load this cycle.
- ld_fun3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- ld_addr  in  AW  load byte address.
- ld_stall  out  1  load blocked this cycle; pipeline must hold the load.
- empty  out  1  no stores queued; used by fence and halt logic.
- mem_read  out  1  to data memory MemRead.
- mem_write  out  1  to data memory MemWrite.
- mem_fun3  out  3  to data memory fun3.
- mem_addr  out  AW  to data memory addr.
- mem_wdata  out  DW  to data memory data_in.

Behaviour:
- Storage:
  - Circular FIFO of DEPTH entries {fun3, addr, data}, with head pointer, tail pointer and a count of width log2(DEPTH)+1.
  - Pointers wrap modulo DEPTH.
- Reset (async, rst=1):
  - count=0, head=tail=0, all queued stores discarded, including stores reset mid-drain.
  - Outputs during and after reset until the first event: st_ready=1, empty=1, ld_stall=0, mem_read=0, mem_write=0, mem_fun3=0, mem_addr=0, mem_wdata=0.
- Status outputs: st_ready = (count != DEPTH); empty = (count == 0). Both decode registered count only; there is no same-cycle pass-through.
- Enqueue: st_valid && st_ready writes the entry at tail on the clock edge; tail++, count++. st_valid while full is ignored; the pipeline must hold the store.
- Illegal store fun3 (not 000/001/010): the handshake completes but nothing is enqueued (dropped).
- Access sizes: 000/100 = 1 byte; 001/101 = 2 bytes; 010 = 4 bytes. A range is [addr, addr+size-1] computed modulo 2^AW, so address 0xFF with size 2 covers 0xFF and 0x00.
- Conflict:
  - Set when ld_valid is high and any valid entry's byte range intersects the load's byte range.
  - The check is combinational over all DEPTH entries.
  - A store enqueued in cycle t takes part in the conflict check from t+1.
- Memory port arbitration, combinational each cycle:
  1. ld_valid && !conflict: mem_read=1, mem_fun3=ld_fun3, mem_addr=ld_addr, mem_write=0, ld_stall=0. Load data returns the same cycle, since memory read is combinational. No drain.
  2. else if count!=0: mem_write=1 with head fun3/addr/data; memory commits on the clock edge, then head++ and count--. ld_stall = ld_valid.
  3. else: mem_read=0, mem_write=0, ld_stall=0, address and data driven 0.
- Simultaneous enqueue and drain: count is unchanged and both pointers advance. When full, the drain frees a slot only from the next cycle.
- Livelock: cannot occur. A conflicting load never blocks the drain, and count strictly decreases until the conflict clears.
- Ordering: stores retire in program order. A load sees all older overlapping stores committed before it reads.
- Latency:
  - An empty-buffer store reaches memory one edge after enqueue, provided no load occupies the port.
  - A conflicting load stalls for at least (position of youngest overlapping entry + 1) cycles.
- st_valid and ld_valid in the same cycle are legal and are handled independently.

Decomposition:
- Shared package mem_pkg holds:
  - fun3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - The access-size function fun3 -> byte count.
  - AW and DW defaults.
  - The store-entry struct {fun3, addr, data}.
- One natural sub-module, range_overlap: a combinational two-range intersection check with wrap. It is instantiated DEPTH times and its outputs are ANDed with entry-valid.

Test Plan:
- Reset mid-drain:
  - Enqueue 3 SW, assert rst for 1 cycle.
  - Expect count=0, empty=1, st_ready=1, mem_write=0.
  - No further memory writes occur, and memory holds only the stores already drained.
- Fill and backpressure:
  - With ld_valid held high at non-overlapping addr 0x80, enqueue 5 SW to 0x00, 0x04, 0x08, 0x0C, 0x10.
  - Expect st_ready=0 after the 4th enqueue; the 5th is held until ld_valid drops.
  - Then 4 writes issue in order on consecutive cycles.
- Conflict stall:
  - Enqueue SW 0x12345678 to 0x04, next cycle LB at 0x06.
  - Expect ld_stall=1 for 1 cycle while mem_write drains the entry.
  - Then mem_read=1, and memory returns 0x00000034.
- No conflict, load priority:
  - Buffer holds SH to 0x20; LW at 0x24.
  - Expect ld_stall=0, mem_read=1, mem_write=0 that cycle, and the store drains the following idle cycle.
- Wrap overlap:
  - Enqueue SH 0xBEEF to 0xFF, then LBU at 0x00.
  - Expect a stall until drained; the load returns 0x000000BE.
- Simultaneous enqueue and drain at count=2:
  - count stays 2, tail and head both advance, and FIFO order is preserved.
- Illegal store:
  - st_fun3=011 with st_valid=1.
  - Expect count unchanged, and no memory write is ever issued for it.
